// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the parametrised hazard scoreboard.
package hazard_scoreboard_pkg;

    // Default Tuse/Tnew field width and the "operand not used" Tuse encoding.
    localparam int TW_DEFAULT = 3;
    localparam logic [TW_DEFAULT-1:0] TUSE_NONE = '1;

    // Forwarding select value meaning "read the register file".
    localparam int FWD_GRF = 0;

    // Multiply/divide occupancy after the operation starts in E.
    localparam int MUL_LAT_DEFAULT = 5;
    localparam int DIV_LAT_DEFAULT = 10;

    // Post-D stage at which mtc0 commits to CP0 (1=E, 2=M, 3=W).
    localparam int CP0_STAGE_DEFAULT = 2;

endpackage

// File: rtl/hazard_md_counter.sv
// Multiply/divide unit busy tracker: loads a latency when an MD op sits in E,
// then counts down to idle. Only reset aborts an operation in progress.
module hazard_md_counter
    import hazard_scoreboard_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEFAULT,
    parameter int DIV_LAT = DIV_LAT_DEFAULT,
    parameter int CW      = $clog2(DIV_LAT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic start_div,
    output logic md_busy
);

    logic [CW-1:0] cnt_r;

    // Busy counter: load on start, otherwise count down to zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r <= '0;
        end else if (start) begin
            cnt_r <= start_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
        end else if (cnt_r != '0) begin
            cnt_r <= cnt_r - CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // The unit is already busy during the cycle the operation sits in E.
    always_comb begin
        md_busy = (cnt_r != '0) || start;
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Parametrised Tuse/Tnew hazard scoreboard: tracks in-flight GRF writers for
// STAGES post-D stages and produces D stall, forwarding selects and MD busy.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int STAGES    = 3,
    parameter int TW        = TW_DEFAULT,
    parameter int AW        = 5,
    parameter int MUL_LAT   = MUL_LAT_DEFAULT,
    parameter int DIV_LAT   = DIV_LAT_DEFAULT,
    parameter int CP0_STAGE = CP0_STAGE_DEFAULT,
    parameter int SW        = $clog2(STAGES + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          d_valid,
    input  logic [AW-1:0] d_rs,
    input  logic [AW-1:0] d_rt,
    input  logic [TW-1:0] d_tuse_rs,
    input  logic [TW-1:0] d_tuse_rt,
    input  logic          d_regwrite,
    input  logic [AW-1:0] d_a3,
    input  logic [TW-1:0] d_tnew,
    input  logic          d_is_md,
    input  logic          d_md_div,
    input  logic          d_is_mdft,
    input  logic          d_is_eret,
    input  logic          d_is_mtc0,
    input  logic          flush,
    output logic          stall,
    output logic [SW-1:0] fwd_rs_sel,
    output logic [SW-1:0] fwd_rt_sel,
    output logic          md_busy
);

    // Scoreboard state, index k = post-D stage (1=E).
    logic [STAGES:1] sb_valid_r;
    logic [STAGES:1] sb_is_md_r;
    logic [STAGES:1] sb_md_div_r;
    logic [STAGES:1] sb_is_mtc0_r;
    logic [AW-1:0]   sb_a3_r   [1:STAGES];
    logic [TW-1:0]   sb_tnew_r [1:STAGES];

    logic [STAGES:1] hit_rs_s;
    logic [STAGES:1] hit_rt_s;
    logic [TW-1:0]   tnew_dec_s [1:STAGES];

    logic          ent_valid_s, ent_is_md_s, ent_md_div_s, ent_is_mtc0_s;
    logic [AW-1:0] ent_a3_s;
    logic [TW-1:0] ent_tnew_s;

    logic          rs_found_s, rt_found_s, mtc0_young_s;
    logic [SW-1:0] rs_stage_s, rt_stage_s;
    logic [TW-1:0] rs_tnew_s, rt_tnew_s;
    logic          stall_s, md_busy_s;

    // Per-stage operand address match and saturating Tnew countdown.
    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
        assign hit_rs_s[k]   = sb_valid_r[k] && (sb_a3_r[k] == d_rs);
        assign hit_rt_s[k]   = sb_valid_r[k] && (sb_a3_r[k] == d_rt);
        assign tnew_dec_s[k] = (sb_tnew_r[k] == '0) ? '0 : sb_tnew_r[k] - TW'(1);
    end

    // Youngest-writer search: walking old-to-young lets the lowest stage win.
    always_comb begin
        rs_found_s   = 1'b0;
        rt_found_s   = 1'b0;
        rs_stage_s   = '0;
        rt_stage_s   = '0;
        rs_tnew_s    = '0;
        rt_tnew_s    = '0;
        mtc0_young_s = 1'b0;
        for (int k = STAGES; k >= 1; k--) begin
            rs_found_s   = hit_rs_s[k] ? 1'b1 : rs_found_s;
            rs_stage_s   = hit_rs_s[k] ? SW'(k) : rs_stage_s;
            rs_tnew_s    = hit_rs_s[k] ? sb_tnew_r[k] : rs_tnew_s;
            rt_found_s   = hit_rt_s[k] ? 1'b1 : rt_found_s;
            rt_stage_s   = hit_rt_s[k] ? SW'(k) : rt_stage_s;
            rt_tnew_s    = hit_rt_s[k] ? sb_tnew_r[k] : rt_tnew_s;
            mtc0_young_s = mtc0_young_s || ((k < CP0_STAGE) && sb_is_mtc0_r[k]);
        end
    end

    // Stall and forwarding decision; a flush squashes the stall so the
    // redirected fetch is not held back.
    always_comb begin
        stall_s    = 1'b0;
        fwd_rs_sel = SW'(FWD_GRF);
        fwd_rt_sel = SW'(FWD_GRF);
        if ((d_rs != '0) && rs_found_s && (rs_tnew_s == '0)) begin
            fwd_rs_sel = rs_stage_s;
        end else begin
            fwd_rs_sel = SW'(FWD_GRF);
        end
        if ((d_rt != '0) && rt_found_s && (rt_tnew_s == '0)) begin
            fwd_rt_sel = rt_stage_s;
        end else begin
            fwd_rt_sel = SW'(FWD_GRF);
        end
        if (flush) begin
            stall_s = 1'b0;
        end else begin
            stall_s = d_valid && (
                      ((d_rs != '0) && rs_found_s && (rs_tnew_s > d_tuse_rs))
                   || ((d_rt != '0) && rt_found_s && (rt_tnew_s > d_tuse_rt))
                   || (d_is_mdft && md_busy_s)
                   || (d_is_eret && mtc0_young_s));
        end
        stall   = stall_s;
        md_busy = md_busy_s;
    end

    // Entry into stage 1: the D instruction if it advances, else a bubble.
    always_comb begin
        ent_valid_s   = 1'b0;
        ent_a3_s      = '0;
        ent_tnew_s    = '0;
        ent_is_md_s   = 1'b0;
        ent_md_div_s  = 1'b0;
        ent_is_mtc0_s = 1'b0;
        if (d_valid && !stall_s) begin
            ent_valid_s   = d_regwrite && (d_a3 != '0);
            ent_a3_s      = d_a3;
            ent_tnew_s    = d_tnew;
            ent_is_md_s   = d_is_md;
            ent_md_div_s  = d_is_md && d_md_div;
            ent_is_mtc0_s = d_is_mtc0;
        end else begin
            ent_valid_s   = 1'b0;
        end
    end

    // Scoreboard shift register; reset and flush empty every stage.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            sb_valid_r   <= '0;
            sb_is_md_r   <= '0;
            sb_md_div_r  <= '0;
            sb_is_mtc0_r <= '0;
            for (int k = 1; k <= STAGES; k++) begin
                sb_a3_r[k]   <= '0;
                sb_tnew_r[k] <= '0;
            end
        end else begin
            for (int k = STAGES; k >= 2; k--) begin
                sb_valid_r[k]   <= sb_valid_r[k-1];
                sb_is_md_r[k]   <= sb_is_md_r[k-1];
                sb_md_div_r[k]  <= sb_md_div_r[k-1];
                sb_is_mtc0_r[k] <= sb_is_mtc0_r[k-1];
                sb_a3_r[k]      <= sb_a3_r[k-1];
                sb_tnew_r[k]    <= tnew_dec_s[k-1];
            end
            sb_valid_r[1]   <= ent_valid_s;
            sb_is_md_r[1]   <= ent_is_md_s;
            sb_md_div_r[1]  <= ent_md_div_s;
            sb_is_mtc0_r[1] <= ent_is_mtc0_s;
            sb_a3_r[1]      <= ent_a3_s;
            sb_tnew_r[1]    <= ent_tnew_s;
        end
    end

    hazard_md_counter #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_md_counter (
        .clk       (clk),
        .reset     (reset),
        .start     (sb_is_md_r[1]),
        .start_div (sb_md_div_r[1]),
        .md_busy   (md_busy_s)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: each scenario drives a table of
// D-stage instructions and checks stall/forwarding/busy against expectations.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       d_valid;
    logic [4:0] d_rs, d_rt, d_a3;
    logic [2:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_regwrite, d_is_md, d_md_div, d_is_mdft, d_is_eret, d_is_mtc0;
    logic       flush;
    logic       stall, md_busy;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs;
        logic [2:0] tuse_rs;
        logic [4:0] rt;
        logic [2:0] tuse_rt;
        logic       regwrite;
        logic [4:0] a3;
        logic [2:0] tnew;
        logic       is_md, md_div, is_mdft, is_eret, is_mtc0, flush, rst_n;
    } step_t;

    typedef struct packed {
        logic       stall;
        logic [1:0] rs_sel;
        logic [1:0] rt_sel;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    hazard_scoreboard dut (
        .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_regwrite(d_regwrite),
        .d_a3(d_a3), .d_tnew(d_tnew), .d_is_md(d_is_md), .d_md_div(d_md_div),
        .d_is_mdft(d_is_mdft), .d_is_eret(d_is_eret), .d_is_mtc0(d_is_mtc0),
        .flush(flush), .stall(stall), .fwd_rs_sel(fwd_rs_sel),
        .fwd_rt_sel(fwd_rt_sel), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    function automatic step_t idle();
        step_t s;
        s = '0;
        s.tuse_rs = TUSE_NONE;
        s.tuse_rt = TUSE_NONE;
        s.rst_n   = 1'b1;
        return s;
    endfunction

    function automatic step_t wr(input logic [4:0] a3, input logic [2:0] tnew);
        step_t s;
        s = idle();
        s.valid = 1'b1; s.regwrite = 1'b1; s.a3 = a3; s.tnew = tnew;
        return s;
    endfunction

    function automatic step_t rd(input logic [4:0] rs, input logic [2:0] trs,
                                 input logic [4:0] rt, input logic [2:0] trt);
        step_t s;
        s = idle();
        s.valid = 1'b1; s.rs = rs; s.tuse_rs = trs; s.rt = rt; s.tuse_rt = trt;
        return s;
    endfunction

    function automatic exp_t ex(input logic st, input logic [1:0] rs,
                                input logic [1:0] rt, input logic busy);
        exp_t e;
        e.stall = st; e.rs_sel = rs; e.rt_sel = rt; e.busy = busy;
        return e;
    endfunction

    // Drive one D-stage instruction at the falling edge and queue its expectation.
    task automatic apply(input step_t s, input exp_t e);
        @(negedge clk);
        reset      = s.rst_n;
        d_valid    = s.valid;
        d_rs       = s.rs;
        d_rt       = s.rt;
        d_tuse_rs  = s.tuse_rs;
        d_tuse_rt  = s.tuse_rt;
        d_regwrite = s.regwrite;
        d_a3       = s.a3;
        d_tnew     = s.tnew;
        d_is_md    = s.is_md;
        d_md_div   = s.md_div;
        d_is_mdft  = s.is_mdft;
        d_is_eret  = s.is_eret;
        d_is_mtc0  = s.is_mtc0;
        flush      = s.flush;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        step_t st[$]; exp_t ev[$]; step_t s; exp_t got, want;
        s = rd(5'd1, 3'd0, 5'd2, 3'd0);
        s.is_mdft = 1'b1; s.is_eret = 1'b1; s.rst_n = 1'b0;
        st.push_back(s);      ev.push_back(ex(1'b0, 2'd0, 2'd0, 1'b0));
        st.push_back(idle()); ev.push_back(ex(1'b0, 2'd0, 2'd0, 1'b0));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i], ev[i]);
            #2;
            got  = {stall, fwd_rs_sel, fwd_rt_sel, md_busy};
            want = exp_q.pop_front();
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("FAIL reset step %0d: got {stall,rs,rt,busy}=%b, expected %b", i, got, want);
            end
        end
    endtask

    task automatic test_load_use();
        step_t st[$]; exp_t ev[$]; step_t s; exp_t got, want;
        st.push_back(wr(5'd1, 3'd2));  ev.push_back(ex(1'b0, 2'd0, 2'd0, 1'b0)); // lw $1
        s = rd(5'd1, 3'd1, 5'd3, 3'd1); s.regwrite = 1'b1; s.a3 = 5'd2; s.tnew = 3'd1;
        st.push_back(s);               ev.push_back(ex(1'b1, 2'd0, 2'd0, 1'b0)); // addu stalls
        st.push_back(s);               ev.push_back(ex(1'b0, 2'd0, 2'd0, 1'b0)); // lw in M, tnew 1
        st.push_back(rd(5'd1, 3'd1, 5'd2, 3'd1));
        ev.push_back(ex(1'b0, 2'd3, 2'd0, 1'b0));                                // $1 from W
        for (int i = 0; i < 3; i++) begin
            st.push_back(idle()); ev.push_back(ex(1'b0, 2'd0, 2'd0, 1'b0));
        end
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i], ev[i]);
            #2;
            got  = {stall, fwd_rs_sel, fwd_rt_sel, md_busy};
            want = exp_q.pop_front();
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("FAIL load_use step %0d: got {stall,rs,rt,busy}=%b, expected %b", i, got, want);
            end
        end
    endtask

    task automatic test_branch();
        step_t st[$]; exp_t ev[$]; exp_t got, want;
        st.push_back(wr(5'd1, 3'd1));                ev.push_back(ex(1'b0, 2'd0, 2'd0, 1'b0));
        st.push_back(rd(5'd1, 3'd0, 5'd0, 3'd7));    ev.push_back(ex(1'b1, 2'd0, 2'd0, 1'b0));
        st.push_back(rd(5'd1, 3'd0, 5'd0, 3'd7));    ev.push_back(ex(1'b0, 2'd2, 2'd0, 1'b0));
        st.push_back(wr(5'd1, 3'd1));                ev.push_back(ex(1'b0, 2'd0, 2'd0, 1'b0));
        st.push_back(rd(5'd0, 3'd0, 5'd0, 3'd7));    ev.push_back(ex(1'b0, 2'd0, 2'd0, 1'b0));
        for (int i = 0; i < 3; i++) begin
            st.push_back(idle()); ev.push_back(ex(1'b0, 2'd0, 2'd0, 1'b0));
        end
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i], ev[i]);
            #2;
            got  = {stall, fwd_rs_sel, fwd_rt_sel, md_busy};
            want = exp_q.pop_front();
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("FAIL branch step %0d: got {stall,rs,rt,busy}=%b, expected %b", i, got, want);
            end
        end
    endtask

    task automatic test_youngest();
        step_t st[$]; exp_t ev[$]; step_t s; exp_t got, want;
        st.push_back(wr(5'd1, 3'd1));  ev.push_back(ex(1'b0, 2'd0, 2'd0, 1'b0));
        st.push_back(wr(5'd1, 3'd0));  ev.push_back(ex(1'b0, 2'd0, 2'd0, 1'b0));
        s = rd(5'd1, 3'd1, 5'd1, 3'd1); s.regwrite = 1'b1; s.a3 = 5'd4; s.tnew = 3'd1;
        st.push_back(s);               ev.push_back(ex(1'b0, 2'd1, 2'd1, 1'b0)); // E wins over M
        st.push_back(wr(5'd1, 3'd1));  ev.push_back(ex(1'b0, 2'd0, 2'd0, 1'b0));
        st.push_back(wr(5'd1, 3'd1));  ev.push_back(ex(1'b0, 2'd0, 2'd0, 1'b0));
        st.push_back(rd(5'd1, 3'd1, 5'd1, 3'd2));
        ev.push_back(ex(1'b0, 2'd0, 2'd0, 1'b0));                                // ready M shadowed
        for (int i = 0; i < 3; i++) begin
            st.push_back(idle()); ev.push_back(ex(1'b0, 2'd0, 2'd0, 1'b0));
        end
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i], ev[i]);
            #2;
            got  = {stall, fwd_rs_sel, fwd_rt_sel, md_busy};
            want = exp_q.pop_front();
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("FAIL youngest step %0d: got {stall,rs,rt,busy}=%b, expected %b", i, got, want);
            end
        end
    endtask

    task automatic test_div_mflo();
        step_t st[$]; exp_t ev[$]; step_t dv, mf; exp_t got, want;
        dv = idle(); dv.valid = 1'b1; dv.is_md = 1'b1; dv.md_div = 1'b1; dv.is_mdft = 1'b1;
        mf = wr(5'd5, 3'd1); mf.is_mdft = 1'b1;
        st.push_back(dv); ev.push_back(ex(1'b0, 2'd0, 2'd0, 1'b0));
        for (int i = 0; i < 11; i++) begin
            st.push_back(mf); ev.push_back(ex(1'b1, 2'd0, 2'd0, 1'b1));
        end
        st.push_back(mf);     ev.push_back(ex(1'b0, 2'd0, 2'd0, 1'b0));
        st.push_back(idle()); ev.push_back(ex(1'b0, 2'd0, 2'd0, 1'b0));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i], ev[i]);
            #2;
            got  = {stall, fwd_rs_sel, fwd_rt_sel, md_busy};
            want = exp_q.pop_front();
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("FAIL div_mflo step %0d: got {stall,rs,rt,busy}=%b, expected %b", i, got, want);
            end
        end
    endtask

    task automatic test_eret_flush();
        step_t st[$]; exp_t ev[$]; step_t mt, er, s; exp_t got, want;
        mt = idle(); mt.valid = 1'b1; mt.is_mtc0 = 1'b1;
        er = idle(); er.valid = 1'b1; er.is_eret = 1'b1;
        st.push_back(mt);             ev.push_back(ex(1'b0, 2'd0, 2'd0, 1'b0));
        st.push_back(er);             ev.push_back(ex(1'b1, 2'd0, 2'd0, 1'b0));
        st.push_back(er);             ev.push_back(ex(1'b0, 2'd0, 2'd0, 1'b0));
        st.push_back(wr(5'd1, 3'd1)); ev.push_back(ex(1'b0, 2'd0, 2'd0, 1'b0));
        st.push_back(mt);             ev.push_back(ex(1'b0, 2'd0, 2'd0, 1'b0));
        s = er; s.rs = 5'd1; s.tuse_rs = 3'd0; s.regwrite = 1'b1; s.a3 = 5'd3; s.tnew = 3'd2;
        s.flush = 1'b1;
        st.push_back(s);              ev.push_back(ex(1'b0, 2'd2, 2'd0, 1'b0)); // flush beats stall
        s = rd(5'd1, 3'd0, 5'd3, 3'd0); s.is_eret = 1'b1;
        st.push_back(s);              ev.push_back(ex(1'b0, 2'd0, 2'd0, 1'b0)); // all cleared
        for (int i = 0; i < 3; i++) begin
            st.push_back(idle()); ev.push_back(ex(1'b0, 2'd0, 2'd0, 1'b0));
        end
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i], ev[i]);
            #2;
            got  = {stall, fwd_rs_sel, fwd_rt_sel, md_busy};
            want = exp_q.pop_front();
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("FAIL eret_flush step %0d: got {stall,rs,rt,busy}=%b, expected %b", i, got, want);
            end
        end
    endtask

    task automatic test_reset_mid_md();
        step_t st[$]; exp_t ev[$]; step_t ml, mf; exp_t got, want;
        ml = idle(); ml.valid = 1'b1; ml.is_md = 1'b1; ml.is_mdft = 1'b1;
        mf = wr(5'd5, 3'd1); mf.is_mdft = 1'b1;
        st.push_back(ml); ev.push_back(ex(1'b0, 2'd0, 2'd0, 1'b0));
        st.push_back(mf); ev.push_back(ex(1'b1, 2'd0, 2'd0, 1'b1));
        st.push_back(mf); ev.push_back(ex(1'b1, 2'd0, 2'd0, 1'b1));
        mf.rst_n = 1'b0;
        st.push_back(mf); ev.push_back(ex(1'b1, 2'd0, 2'd0, 1'b1)); // state still busy pre-edge
        mf.rst_n = 1'b1;
        st.push_back(mf); ev.push_back(ex(1'b0, 2'd0, 2'd0, 1'b0)); // count aborted
        st.push_back(idle()); ev.push_back(ex(1'b0, 2'd0, 2'd0, 1'b0));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i], ev[i]);
            #2;
            got  = {stall, fwd_rs_sel, fwd_rt_sel, md_busy};
            want = exp_q.pop_front();
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("FAIL reset_mid_md step %0d: got {stall,rs,rt,busy}=%b, expected %b", i, got, want);
            end
        end
    endtask

    initial begin
        reset = 1'b0; d_valid = 1'b0; d_rs = '0; d_rt = '0;
        d_tuse_rs = TUSE_NONE; d_tuse_rt = TUSE_NONE; d_regwrite = 1'b0;
        d_a3 = '0; d_tnew = '0; d_is_md = 1'b0; d_md_div = 1'b0; d_is_mdft = 1'b0;
        d_is_eret = 1'b0; d_is_mtc0 = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_load_use();
        test_branch();
        test_youngest();
        test_div_mflo();
        test_eret_flush();
        test_reset_mid_md();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
